// File: rtl/obj_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : obj_ram_arbiter_if
// Purpose  : Bundles the requester handshake and the object RAM write port
//            shared by obj_ram_arbiter and the blocks around it.
// Signals  : iReq/iAddr/iData - packed per-requester write requests
//            oGnt             - one-hot grant pulse back to the requesters
//            oObjRam_*        - registered object RAM write port
// Modports : master - requesters plus RAM side (drives requests)
//            slave  - the arbiter (drives grants and the RAM port)
// Revision : 1.0 - initial release
// ============================================================================
interface obj_ram_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 13
);
    logic [NUM_REQ-1:0]        iReq;
    logic [NUM_REQ*ADDR_W-1:0] iAddr;
    logic [NUM_REQ*DATA_W-1:0] iData;
    logic [NUM_REQ-1:0]        oGnt;
    logic [ADDR_W-1:0]         oObjRam_addr;
    logic [DATA_W-1:0]         oObjRam_data;
    logic                      oObjRam_we;

    modport master (
        output iReq, iAddr, iData,
        input  oGnt, oObjRam_addr, oObjRam_data, oObjRam_we
    );

    modport slave (
        input  iReq, iAddr, iData,
        output oGnt, oObjRam_addr, oObjRam_data, oObjRam_we
    );
endinterface
`default_nettype wire

// File: rtl/obj_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : obj_ram_arbiter
// Purpose  : Round-robin arbiter sharing the object RAM write port between
//            NUM_REQ writers. Writes are only accepted inside a WIN_LEN-cycle
//            window opened by each falling edge of iVS. After reset every
//            RAM entry is cleared before any request is served.
// Ports    : clk       - system clock
//            reset_n   - synchronous active-low reset
//            iVS       - vertical sync, falling edge starts a frame
//            bus       - requests, grants and RAM write port (slave side)
//            oWindow   - write window open
//            oInitDone - post-reset clear finished
//            oOverrun  - a request was left pending when the last window closed
// Revision : 1.0 - initial release
// ============================================================================
module obj_ram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 13,
    parameter int WIN_LEN = 64
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire              iVS,
    obj_ram_arbiter_if.slave bus,
    output logic             oWindow,
    output logic             oInitDone,
    output logic             oOverrun
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_WINDOW = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [ADDR_W-1:0]    clr_addr_q,  clr_addr_d;
    logic [7:0]           win_cnt_q,   win_cnt_d;
    logic [c_ptr_w-1:0]   rr_ptr_q,    rr_ptr_d;
    logic                 last_vs_q,   last_vs_d;
    logic [NUM_REQ-1:0]   gnt_q,       gnt_d;
    logic                 we_q,        we_d;
    logic [ADDR_W-1:0]    addr_q,      addr_d;
    logic [DATA_W-1:0]    data_q,      data_d;
    logic                 window_q,    window_d;
    logic                 init_done_q, init_done_d;
    logic                 overrun_q,   overrun_d;

    logic                 w_frame_syn;
    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_found;
    logic [c_ptr_w-1:0]   w_win;
    logic [ADDR_W-1:0]    w_win_addr;
    logic [DATA_W-1:0]    w_win_data;

    always_comb begin
        w_frame_syn = last_vs_q & ~iVS;
        // A requester granted last cycle is masked so its stale entry is not
        // written twice before it has had a chance to update or drop.
        w_elig      = bus.iReq & ~gnt_q;

        // Round-robin search: first pass covers indices >= rr_ptr, second pass
        // wraps to the lowest eligible index below the pointer.
        w_found    = 1'b0;
        w_win      = '0;
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_elig[i] && (c_ptr_w'(i) >= rr_ptr_q)) begin
                w_found    = 1'b1;
                w_win      = c_ptr_w'(i);
                w_win_addr = bus.iAddr[i*ADDR_W +: ADDR_W];
                w_win_data = bus.iData[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_elig[i]) begin
                w_found    = 1'b1;
                w_win      = c_ptr_w'(i);
                w_win_addr = bus.iAddr[i*ADDR_W +: ADDR_W];
                w_win_data = bus.iData[i*DATA_W +: DATA_W];
            end
        end

        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        win_cnt_d   = win_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        last_vs_d   = iVS;
        gnt_d       = '0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        window_d    = window_q;
        // Sticky once the clear sequence has handed over to normal operation.
        init_done_d = init_done_q | (state_q != S_INIT);
        overrun_d   = overrun_q;

        case (state_q)
            S_INIT: begin
                we_d       = 1'b1;
                addr_d     = clr_addr_q;
                data_d     = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_frame_syn) begin
                    state_d   = S_WINDOW;
                    win_cnt_d = 8'(WIN_LEN - 1);
                    window_d  = 1'b1;
                    overrun_d = 1'b0;
                end
            end
            S_WINDOW: begin
                if (w_found) begin
                    gnt_d    = NUM_REQ'(1) << w_win;
                    we_d     = 1'b1;
                    addr_d   = w_win_addr;
                    data_d   = w_win_data;
                    rr_ptr_d = (w_win == c_ptr_w'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                end
                // A new frame edge restarts the window and takes priority
                // over the normal close.
                if (w_frame_syn) begin
                    win_cnt_d = 8'(WIN_LEN - 1);
                end else if (win_cnt_q == 8'd0) begin
                    state_d   = S_IDLE;
                    window_d  = 1'b0;
                    overrun_d = |(bus.iReq & ~gnt_d);
                end else begin
                    win_cnt_d = win_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            clr_addr_q  <= '0;
            win_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            last_vs_q   <= 1'b0;
            gnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            window_q    <= 1'b0;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            win_cnt_q   <= win_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            last_vs_q   <= last_vs_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            window_q    <= window_d;
            init_done_q <= init_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.oGnt         = gnt_q;
    assign bus.oObjRam_we   = we_q;
    assign bus.oObjRam_addr = addr_q;
    assign bus.oObjRam_data = data_q;
    assign oWindow          = window_q;
    assign oInitDone        = init_done_q;
    assign oOverrun         = overrun_q;

endmodule
`default_nettype wire
